multi_pad_counter: RTL and testbench
====================================

# multi_pad_counter

Parametrised press counter for momentary pads, generalising the three-pad counter to NUM_PADS channels. Each pad gets a synchroniser, debouncer and rising-edge detector feeding its own two-digit BCD counter with configurable wrap or saturation. All counters appear on a time-multiplexed 8-position seven-segment display. A single-cycle press pulse and the last-pressed pad index are exported.

## Interface
- NUM_PADS, 3, number of pads/counters, legal 1..4
- DEB_CYCLES, 4, consecutive stable synchronised samples required to change a debounced level, legal 2..65535
- SCAN_DIV, 8, clock cycles per display position, legal 1..65535
- WRAP, 1, 1: 99+press→00; 0: saturate at 99
- SSD_ACTIVE_LOW, 1, 1: segment outputs are active-low; 0: active-high

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pad  in  NUM_PADS  raw pad levels, high = pressed, bit i = pad i
- clr  in  1  synchronous clear of all counters
- pad_pos_out  out  1  one-cycle pulse per accepted press event
- press_id  out  2  index of the pad that caused the latest pulse
- dig  out  8  digit enables, one-hot, active-low, bit p = position p
- ssd  out  8  segments {dp,g,f,e,d,c,b,a}, polarity per SSD_ACTIVE_LOW

## Operation
- Per pad: 2-flop synchroniser → debouncer → rising-edge detect. Only presses count; releases are debounced but generate no event.
- Debouncer: the stability counter increments each cycle the synchronised level differs from the debounced level. It clears on any matching sample. On reaching DEB_CYCLES, the debounced level flips and the counter clears. Glitches shorter than DEB_CYCLES are ignored.
- Counters: 2-digit BCD, 00..99, ones digit rolls 9→0 with carry. Behaviour at 99 is set by WRAP.
- Simultaneous presses: every pressed counter increments, pad_pos_out pulses once, and press_id = lowest pressed index.
- clr: all counters become 00 on the next edge. clr overrides presses in the same cycle, but pad_pos_out/press_id still report those presses.
- Display: scan position 0..7 advances every SCAN_DIV cycles and wraps 7→0.
  - Position p shows pad p/2: even p = ones digit, odd p = tens digit.
  - Positions ≥ 2*NUM_PADS: dig all high, segments off.
- dp: lit only at the ones position of pad press_id, and only after the first press since reset.
- Active-high encodings: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. SSD_ACTIVE_LOW inverts all 8 bits.

## Timing
- Reset values:
  - pad_pos_out 0, press_id 0, dig FF.
  - ssd FF (active-low) or 00 (active-high).
  - All counters 00, scan position 0, debounced levels 0, synchronisers 0, dp-valid flag 0.
- Press latency: a raw pad first sampled high at edge t, held stable, gives pad_pos_out high for exactly the cycle after edge t+DEB_CYCLES+2 (L = DEB_CYCLES+3 edges). The counter value and press_id update on that same edge.
- Release needs DEB_CYCLES+2 stable low cycles before a new press can be recognised.
- dig/ssd are registered and change one cycle after the scan position changes. A new count is visible at the next visit of its positions.
- Reset mid-operation clears everything immediately. A pad held through reset release counts once, L cycles after release.
- No combinational path from any input to any output.

## Structure
- Package pad_pkg:
  - seven-segment digit constants 0–9 and blank;
  - segment bit-order constants;
  - function ssd_encode(bcd, dp);
  - BCD digit typedef.
- Sub-module pad_debounce (synchroniser, debouncer, edge pulse; parameter DEB_CYCLES), instantiated NUM_PADS times.
- The top level holds the BCD counters, the clr/priority logic, the scan counter and the output registers.

## Test plan
- Defaults, clean press on pad 0 held 20 cycles → pad_pos_out pulses once at cycle 7 after press start; press_id=0; pad 0 count 01.
- Pad 1 glitch of 3 cycles high → no pulse, count stays 00. Glitch of 4+ cycles → pulse, count 01.
- Pads 0 and 2 rise in the same cycle → one pulse, press_id=0, both counts 01.
- Pad 2 pressed 100 times:
  - WRAP=1 → count 00;
  - WRAP=0 → count 99, no change on press 101, pulses continue.
- Counts 03/00/00, scan to position 0 → dig=FE, ssd=B0 (active-low "3", no dp until pressed). After pad 0 is last pressed → ssd=30 (dp lit).
- rst asserted mid-count with pad 1 held → outputs at reset values immediately. After release: one press, count 01 at cycle L.

Source files
------------

// File: rtl/pad_pkg.sv
// Shared types and seven-segment helpers for the multi-pad press counter.
package pad_pkg;

   typedef logic [3:0] bcd_t;

   // Segment bit positions within the {dp,g,f,e,d,c,b,a} byte
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Active-high glyphs
   localparam logic [7:0] SSD_0     = 8'h3F;
   localparam logic [7:0] SSD_1     = 8'h06;
   localparam logic [7:0] SSD_2     = 8'h5B;
   localparam logic [7:0] SSD_3     = 8'h4F;
   localparam logic [7:0] SSD_4     = 8'h66;
   localparam logic [7:0] SSD_5     = 8'h6D;
   localparam logic [7:0] SSD_6     = 8'h7D;
   localparam logic [7:0] SSD_7     = 8'h07;
   localparam logic [7:0] SSD_8     = 8'h7F;
   localparam logic [7:0] SSD_9     = 8'h6F;
   localparam logic [7:0] SSD_BLANK = 8'h00;

   // Active-high glyph for one BCD digit with optional decimal point
   function automatic logic [7:0] ssd_encode(input bcd_t bcd, input logic dp);
      logic [7:0] s;
      case (bcd)
         4'd0:    s = SSD_0;
         4'd1:    s = SSD_1;
         4'd2:    s = SSD_2;
         4'd3:    s = SSD_3;
         4'd4:    s = SSD_4;
         4'd5:    s = SSD_5;
         4'd6:    s = SSD_6;
         4'd7:    s = SSD_7;
         4'd8:    s = SSD_8;
         4'd9:    s = SSD_9;
         default: s = SSD_BLANK;
      endcase
      s[SEG_DP] = dp;
      return s;
   endfunction

endpackage

// File: rtl/pad_debounce.sv
// One pad channel: 2-flop synchroniser, stability-count debouncer and a
// registered one-cycle pulse on each debounced rising transition.
module pad_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pad_i,
   output logic rise_o
);

   localparam logic [15:0] DEB_M1 = 16'(DEB_CYCLES - 1);

   logic        sync1_q, sync2_q;
   logic        deb_q, deb_d;
   logic        rise_q, rise_d;
   logic [15:0] cnt_q, cnt_d;

   // Count consecutive samples disagreeing with the debounced level; flip on the last one
   always_comb begin
      cnt_d  = cnt_q;
      deb_d  = deb_q;
      rise_d = 1'b0;
      if (sync2_q != deb_q) begin
         if (cnt_q == DEB_M1) begin
            cnt_d  = '0;
            deb_d  = sync2_q;
            rise_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Synchroniser and debouncer state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= pad_i;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/multi_pad_counter.sv
// NUM_PADS debounced press counters (2-digit BCD) shown on a scanned
// 8-position seven-segment display, with press pulse and last-pad index.
module multi_pad_counter
   import pad_pkg::*;
#(
   parameter int NUM_PADS       = 3,
   parameter int DEB_CYCLES     = 4,
   parameter int SCAN_DIV       = 8,
   parameter bit WRAP           = 1'b1,
   parameter bit SSD_ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_PADS-1:0] pad,
   input  logic                clr,
   output logic                pad_pos_out,
   output logic [1:0]          press_id,
   output logic [7:0]          dig,
   output logic [7:0]          ssd
);

   localparam logic [15:0] SCAN_M1   = 16'(SCAN_DIV - 1);
   localparam logic [7:0]  SSD_RESET = SSD_ACTIVE_LOW ? 8'hFF : 8'h00;

   logic [NUM_PADS-1:0] rise;

   for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
      pad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk   (clk),
         .rst   (rst),
         .pad_i (pad[g]),
         .rise_o(rise[g])
      );
   end

   bcd_t [NUM_PADS-1:0] ones_q, ones_d, tens_q, tens_d;
   logic                pulse_q, pulse_d;
   logic [1:0]          id_q, id_d;
   logic                dpv_q, dpv_d;
   logic [15:0]         div_q, div_d;
   logic [2:0]          pos_q, pos_d;
   logic [7:0]          dig_q, dig_d, ssd_q, ssd_d;
   logic [7:0]          seg;

   // Counter update, clr override and lowest-index press priority
   always_comb begin
      ones_d  = ones_q;
      tens_d  = tens_q;
      pulse_d = |rise;
      id_d    = id_q;
      dpv_d   = dpv_q | (|rise);
      for (int i = NUM_PADS - 1; i >= 0; i--) begin
         if (rise[i]) id_d = 2'(i);
      end
      for (int i = 0; i < NUM_PADS; i++) begin
         if (clr) begin
            ones_d[i] = '0;
            tens_d[i] = '0;
         end else if (rise[i]) begin
            if (ones_q[i] != 4'd9) begin
               ones_d[i] = ones_q[i] + 4'd1;
            end else if (tens_q[i] != 4'd9) begin
               ones_d[i] = '0;
               tens_d[i] = tens_q[i] + 4'd1;
            end else if (WRAP) begin
               ones_d[i] = '0;
               tens_d[i] = '0;
            end
         end
      end
   end

   // Scan position advances once every SCAN_DIV cycles
   always_comb begin
      div_d = div_q + 16'd1;
      pos_d = pos_q;
      if (div_q == SCAN_M1) begin
         div_d = '0;
         pos_d = pos_q + 3'd1;
      end
   end

   // Digit/segment selection for the current scan position; unused positions stay dark
   always_comb begin
      dig_d = 8'hFF;
      seg   = SSD_BLANK;
      for (int i = 0; i < NUM_PADS; i++) begin
         if (pos_q[2:1] == 2'(i)) begin
            dig_d = ~(8'd1 << pos_q);
            seg   = ssd_encode(pos_q[0] ? tens_q[i] : ones_q[i],
                               !pos_q[0] && dpv_q && (id_q == 2'(i)));
         end
      end
      ssd_d = SSD_ACTIVE_LOW ? ~seg : seg;
   end

   // All architectural state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ones_q  <= '0;
         tens_q  <= '0;
         pulse_q <= 1'b0;
         id_q    <= '0;
         dpv_q   <= 1'b0;
         div_q   <= '0;
         pos_q   <= '0;
         dig_q   <= 8'hFF;
         ssd_q   <= SSD_RESET;
      end else begin
         ones_q  <= ones_d;
         tens_q  <= tens_d;
         pulse_q <= pulse_d;
         id_q    <= id_d;
         dpv_q   <= dpv_d;
         div_q   <= div_d;
         pos_q   <= pos_d;
         dig_q   <= dig_d;
         ssd_q   <= ssd_d;
      end
   end

   assign pad_pos_out = pulse_q;
   assign press_id    = id_q;
   assign dig         = dig_q;
   assign ssd         = ssd_q;

endmodule

// File: tb/tb_multi_pad_counter.sv
// Bench for multi_pad_counter: two instances (wrap/active-low and
// saturate/active-high) driven in parallel and compared every cycle
// against an event-level reference model.
module tb_multi_pad_counter;

   localparam int NP  = 3;
   localparam int DEB = 4;
   localparam int SD  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr = 1'b0;
   logic [NP-1:0] pad = '0;

   logic       pulse_a, pulse_b;
   logic [1:0] id_a, id_b;
   logic [7:0] dig_a, dig_b, ssd_a, ssd_b;

   multi_pad_counter #(.NUM_PADS(NP), .DEB_CYCLES(DEB), .SCAN_DIV(SD),
                       .WRAP(1'b1), .SSD_ACTIVE_LOW(1'b1)) dut_a (
      .clk(clk), .rst(rst), .pad(pad), .clr(clr),
      .pad_pos_out(pulse_a), .press_id(id_a), .dig(dig_a), .ssd(ssd_a));

   multi_pad_counter #(.NUM_PADS(NP), .DEB_CYCLES(DEB), .SCAN_DIV(SD),
                       .WRAP(1'b0), .SSD_ACTIVE_LOW(1'b0)) dut_b (
      .clk(clk), .rst(rst), .pad(pad), .clr(clr),
      .pad_pos_out(pulse_b), .press_id(id_b), .dig(dig_b), .ssd(ssd_b));

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: counts as plain integers, press events scheduled by edge number
   int            cnt_a[NP], cnt_b[NP], pcnt_a[NP], pcnt_b[NP];
   int            lvl[NP], run[NP], rem[NP];
   int            n, id, pid;
   bit            dpv, pdpv;
   logic [NP-1:0] ev[int];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h at edge %0d", tag, obs, exp, n);
      end
   endtask

   function automatic logic [7:0] seg7(input int d);
      case (d)
         0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
         4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
         8: return 8'h7F;  9: return 8'h6F;
         default: return 8'h00;
      endcase
   endfunction

   // Active-high segments expected at scan position p from the previous-edge model state
   function automatic logic [7:0] exp_seg(input bit b, input int p);
      logic [7:0] s;
      int v, k;
      k = p / 2;
      if (k >= NP) return 8'h00;
      v = b ? pcnt_b[k] : pcnt_a[k];
      s = seg7((p % 2 == 1) ? v / 10 : v % 10);
      if (p % 2 == 0 && pdpv && pid == k) s[7] = 1'b1;
      return s;
   endfunction

   function automatic logic [7:0] exp_dig(input int p);
      logic [7:0] d;
      d = 8'hFF;
      if (p / 2 < NP) d[p] = 1'b0;
      return d;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         cnt_a[i] = 0; cnt_b[i] = 0; lvl[i] = 0; run[i] = 0;
      end
      ev.delete();
      n = 0; id = 0; dpv = 0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_pulse_a", {7'd0, pulse_a}, 8'h00);
      chk("rst_id_a",    {6'd0, id_a},    8'h00);
      chk("rst_dig_a",   dig_a,           8'hFF);
      chk("rst_ssd_a",   ssd_a,           8'hFF);
      chk("rst_pulse_b", {7'd0, pulse_b}, 8'h00);
      chk("rst_dig_b",   dig_b,           8'hFF);
      chk("rst_ssd_b",   ssd_b,           8'h00);
   endtask

   // One clock: advance the model on the edge, then compare every output
   task automatic step();
      logic [NP-1:0] e;
      int p;
      @(posedge clk);
      if (rst) begin
         #1 chk_reset_vals();
      end else begin
         n++;
         pcnt_a = cnt_a; pcnt_b = cnt_b; pdpv = dpv; pid = id;
         for (int i = 0; i < NP; i++) begin
            if (int'(pad[i]) != lvl[i]) begin
               run[i]++;
               if (run[i] == DEB) begin
                  lvl[i] = int'(pad[i]);
                  run[i] = 0;
                  if (lvl[i] == 1) begin
                     if (!ev.exists(n + 3)) ev[n + 3] = '0;
                     ev[n + 3][i] = 1'b1;
                  end
               end
            end else begin
               run[i] = 0;
            end
         end
         e = '0;
         if (ev.exists(n)) begin
            e = ev[n];
            ev.delete(n);
         end
         if (e != '0) begin
            dpv = 1;
            for (int i = NP - 1; i >= 0; i--) if (e[i]) id = i;
         end
         for (int i = 0; i < NP; i++) begin
            if (clr) begin
               cnt_a[i] = 0; cnt_b[i] = 0;
            end else if (e[i]) begin
               cnt_a[i] = (cnt_a[i] == 99) ? 0  : cnt_a[i] + 1;
               cnt_b[i] = (cnt_b[i] == 99) ? 99 : cnt_b[i] + 1;
            end
         end
         p = ((n - 1) / SD) % 8;
         #1;
         chk("pulse_a", {7'd0, pulse_a}, {7'd0, (e != '0)});
         chk("pulse_b", {7'd0, pulse_b}, {7'd0, (e != '0)});
         chk("id_a",    {6'd0, id_a},    8'(id));
         chk("id_b",    {6'd0, id_b},    8'(id));
         chk("dig_a",   dig_a,           exp_dig(p));
         chk("dig_b",   dig_b,           exp_dig(p));
         chk("ssd_a",   ssd_a,           ~exp_seg(1'b0, p));
         chk("ssd_b",   ssd_b,           exp_seg(1'b1, p));
      end
   endtask

   task automatic hold(input logic [NP-1:0] v, input int cycles);
      pad = v;
      repeat (cycles) step();
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      #1 chk_reset_vals();
      model_reset();
      repeat (cycles) step();
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (3) step();
      rst = 1'b0;
      hold('0, 5);

      // Clean press on pad 0, then glitches on pad 1 (3 cycles rejected, 4 accepted)
      hold(3'b001, 20);
      hold(3'b000, 10);
      hold(3'b010, 3);
      hold(3'b000, 10);
      hold(3'b010, 4);
      hold(3'b000, 10);

      // Pads 0 and 2 together: one pulse, lowest index reported
      hold(3'b101, 20);
      hold(3'b000, 10);

      // Pad 2 pressed 100 times: wraps on one instance, saturates on the other
      repeat (100) begin
         hold(3'b100, 5);
         hold(3'b000, 5);
      end
      hold(3'b000, 70);

      // Clear, then clear coinciding with a press event
      clr = 1'b1; step(); clr = 1'b0;
      hold(3'b001, DEB + 2);
      clr = 1'b1; step(); clr = 1'b0;
      hold(3'b001, 10);
      hold(3'b000, 70);

      // Random pad activity with occasional clears
      for (int i = 0; i < NP; i++) rem[i] = $urandom_range(1, 9);
      repeat (2500) begin
         for (int i = 0; i < NP; i++) begin
            if (rem[i] == 0) begin
               pad[i] = ~pad[i];
               rem[i] = $urandom_range(1, 9);
            end
            rem[i]--;
         end
         clr = ($urandom_range(0, 47) == 0);
         step();
      end
      clr = 1'b0;
      hold(3'b000, 20);

      // Reset mid-operation with pad 1 held through release
      hold(3'b010, 3);
      do_reset(4);
      hold(3'b010, 20);
      hold(3'b000, 80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
